// File: rtl/life_hud_renderer_pkg.sv
// Shared definitions for the life/gameover HUD renderer: colours, FSM states and the heart glyph.
// The glyph is stored MSB-first so that column 0 is the leftmost pixel of each row.
package life_hud_renderer_pkg;

    localparam logic [11:0] RGB_FILLED = 12'hF00;
    localparam logic [11:0] RGB_EMPTY  = 12'h444;
    localparam logic [11:0] RGB_BANNER = 12'h800;
    localparam logic [11:0] RGB_BORDER = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLASH,
        ST_GAMEOVER
    } hud_state_t;

    // 8x8 heart, row 0 in the top byte.
    localparam logic [63:0] HEART_BITMAP = 64'h66FF_FFFF_7E3C_1800;

    function automatic logic heart_bit(input logic [2:0] row, input logic [2:0] col);
        logic [5:0] idx;
        idx = 6'd63 - {row, 3'b000} - {3'b000, col};
        return HEART_BITMAP[idx];
    endfunction

endpackage

// File: rtl/life_hud_renderer_if.sv
// Scan-position / life-status inputs and HUD pixel outputs of the renderer.
// The pixel pipeline is the master; the renderer is the slave.
interface life_hud_renderer_if;

    logic        frame_tick;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [2:0]  life;
    logic        gameover;
    logic        hud_on;
    logic [11:0] hud_rgb;
    logic        flash_active;

    modport master (
        output frame_tick, pixel_x, pixel_y, life, gameover,
        input  hud_on, hud_rgb, flash_active
    );

    modport slave (
        input  frame_tick, pixel_x, pixel_y, life, gameover,
        output hud_on, hud_rgb, flash_active
    );

endinterface

// File: rtl/life_hud_renderer_hud_slot_decoder.sv
// Maps a scan position onto a heart slot: whether it is inside one, which one,
// and the glyph row/column after the x2 scale.
module hud_slot_decoder #(
    parameter int MAX_LIFE   = 5,
    parameter int HUD_X0     = 8,
    parameter int HUD_Y0     = 8,
    parameter int SLOT_PITCH = 20
) (
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    output logic       o_in_slot,
    output logic [2:0] o_slot_idx,
    output logic [2:0] o_row,
    output logic [2:0] o_col
);

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_in_row;

    // One extra bit so origin+16 never wraps for columns near 1023.
    assign w_x      = {1'b0, i_pixel_x};
    assign w_y      = {1'b0, i_pixel_y};
    assign w_in_row = (w_y >= 11'(HUD_Y0)) && (w_y < 11'(HUD_Y0 + 16));
    assign o_row    = 3'((w_y - 11'(HUD_Y0)) >> 1);

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        o_in_slot  = 1'b0;
        o_slot_idx = '0;
        o_col      = '0;
        for (int i = 0; i < MAX_LIFE; i++) begin
            if (w_in_row &&
                (w_x >= 11'(HUD_X0 + i * SLOT_PITCH)) &&
                (w_x <  11'(HUD_X0 + i * SLOT_PITCH + 16))) begin
                o_in_slot  = 1'b1;
                o_slot_idx = 3'(i);
                o_col      = 3'((w_x - 11'(HUD_X0 + i * SLOT_PITCH)) >> 1);
            end
        end
    end

endmodule

// File: rtl/life_hud_renderer.sv
// HUD overlay: heart row with lost-heart blinking and a blinking GAME OVER banner.
// Life status is latched once per frame; pixel outputs are registered (1-cycle latency).
module life_hud_renderer
    import life_hud_renderer_pkg::*;
#(
    parameter int MAX_LIFE     = 5,
    parameter int HUD_X0       = 8,
    parameter int HUD_Y0       = 8,
    parameter int SLOT_PITCH   = 20,
    parameter int FLASH_FRAMES = 32,
    parameter int BANNER_W     = 192,
    parameter int BANNER_H     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    life_hud_renderer_if.slave   hud
);

    localparam int FC_W = $clog2(FLASH_FRAMES);
    localparam int BX0  = 320 - BANNER_W / 2;
    localparam int BX1  = BX0 + BANNER_W;
    localparam int BY0  = 240 - BANNER_H / 2;
    localparam int BY1  = BY0 + BANNER_H;

    hud_state_t      r_state, w_state_nxt;
    logic [2:0]      r_life_q;
    logic [5:0]      r_frame_cnt;
    logic [FC_W-1:0] r_flash_cnt, w_flash_cnt_nxt;
    logic [2:0]      r_flash_lo, w_flash_lo_nxt;
    logic [2:0]      r_flash_hi, w_flash_hi_nxt;

    logic [2:0]      w_life_c;
    logic            w_in_slot;
    logic [2:0]      w_slot_idx, w_row, w_col;
    logic [10:0]     w_x, w_y;
    logic            w_in_banner, w_on_border, w_lit;
    logic            w_hud_on, w_flash_active;
    logic [11:0]     w_hud_rgb;
    logic            r_hud_on, r_flash_active;
    logic [11:0]     r_hud_rgb;

    assign w_life_c = (hud.life > 3'(MAX_LIFE)) ? 3'(MAX_LIFE) : hud.life;

    hud_slot_decoder #(
        .MAX_LIFE   (MAX_LIFE),
        .HUD_X0     (HUD_X0),
        .HUD_Y0     (HUD_Y0),
        .SLOT_PITCH (SLOT_PITCH)
    ) u_slot_decoder (
        .i_pixel_x  (hud.pixel_x),
        .i_pixel_y  (hud.pixel_y),
        .o_in_slot  (w_in_slot),
        .o_slot_idx (w_slot_idx),
        .o_row      (w_row),
        .o_col      (w_col)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_life_q    <= 3'(MAX_LIFE);
            r_frame_cnt <= '0;
            r_flash_cnt <= '0;
            r_flash_lo  <= '0;
            r_flash_hi  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flash_cnt <= w_flash_cnt_nxt;
            r_flash_lo  <= w_flash_lo_nxt;
            r_flash_hi  <= w_flash_hi_nxt;
            if (hud.frame_tick) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
                r_life_q    <= w_life_c;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flash_cnt_nxt = r_flash_cnt;
        w_flash_lo_nxt  = r_flash_lo;
        w_flash_hi_nxt  = r_flash_hi;
        if (hud.frame_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (hud.gameover) begin
                        w_state_nxt = ST_GAMEOVER;
                    end else if (w_life_c < r_life_q) begin
                        w_state_nxt     = ST_FLASH;
                        w_flash_lo_nxt  = w_life_c;
                        w_flash_hi_nxt  = r_life_q;
                        w_flash_cnt_nxt = FC_W'(FLASH_FRAMES - 1);
                    end
                end
                ST_FLASH: begin
                    if (hud.gameover) begin
                        w_state_nxt = ST_GAMEOVER;
                    end else if (w_life_c < r_life_q) begin
                        // A further drop widens the blink downwards; the top slot is kept.
                        w_flash_lo_nxt  = w_life_c;
                        w_flash_cnt_nxt = FC_W'(FLASH_FRAMES - 1);
                    end else if (w_life_c > r_life_q) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_flash_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_flash_cnt_nxt = r_flash_cnt - FC_W'(1);
                    end
                end
                ST_GAMEOVER: begin
                    if (!hud.gameover) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_x         = {1'b0, hud.pixel_x};
    assign w_y         = {1'b0, hud.pixel_y};
    assign w_in_banner = (w_x >= 11'(BX0)) && (w_x < 11'(BX1)) &&
                         (w_y >= 11'(BY0)) && (w_y < 11'(BY1));
    assign w_on_border = (w_x < 11'(BX0 + 2)) || (w_x >= 11'(BX1 - 2)) ||
                         (w_y < 11'(BY0 + 2)) || (w_y >= 11'(BY1 - 2));

    always_comb begin
        w_hud_on       = 1'b0;
        w_hud_rgb      = '0;
        w_lit          = 1'b0;
        w_flash_active = (r_state == ST_FLASH);
        if (w_in_slot && heart_bit(w_row, w_col)) begin
            w_lit = (r_state != ST_GAMEOVER) && (w_slot_idx < r_life_q);
            if (r_state == ST_FLASH && w_slot_idx >= r_flash_lo && w_slot_idx < r_flash_hi) begin
                w_lit = r_frame_cnt[2];
            end
            w_hud_on  = 1'b1;
            w_hud_rgb = w_lit ? RGB_FILLED : RGB_EMPTY;
        end
        // Banner is drawn last so it overlays anything underneath it.
        if (r_state == ST_GAMEOVER && !r_frame_cnt[4] && w_in_banner) begin
            w_hud_on  = 1'b1;
            w_hud_rgb = w_on_border ? RGB_BORDER : RGB_BANNER;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hud_on       <= 1'b0;
            r_hud_rgb      <= '0;
            r_flash_active <= 1'b0;
        end else begin
            r_hud_on       <= w_hud_on;
            r_hud_rgb      <= w_hud_rgb;
            r_flash_active <= w_flash_active;
        end
    end

    assign hud.hud_on       = r_hud_on;
    assign hud.hud_rgb      = r_hud_rgb;
    assign hud.flash_active = r_flash_active;

endmodule

// File: tb/tb_life_hud_renderer.sv
// Randomised and directed bench for life_hud_renderer against a frame-level model
// of the heart row, blink timing and banner geometry.
module tb_life_hud_renderer;

    logic clk = 1'b0;
    logic reset_n;

    life_hud_renderer_if hud_if ();

    life_hud_renderer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hud     (hud_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: mode 0 = normal, 1 = blinking, 2 = game over.
    int m_mode, m_life, m_lo, m_hi, m_left, m_frame;

    string heart_art [8] = '{".##..##.", "########", "########", "########",
                             ".######.", "..####..", "...##...", "........"};

    function automatic void model_reset();
        m_mode  = 0;
        m_life  = 5;
        m_lo    = 0;
        m_hi    = 0;
        m_left  = 0;
        m_frame = 0;
    endfunction

    function automatic void model_tick(input int l, input bit g);
        int lc;
        lc = (l > 5) ? 5 : l;
        if (m_mode == 2) begin
            if (!g) m_mode = 0;
        end else if (g) begin
            m_mode = 2;
        end else if (lc < m_life) begin
            if (m_mode == 0) m_hi = m_life;
            m_mode = 1;
            m_lo   = lc;
            m_left = 32;
        end else if (m_mode == 1) begin
            // A blink lasts 32 frames after the drop; a refill ends it at once.
            m_left = m_left - 1;
            if (lc > m_life || m_left == 0) m_mode = 0;
        end
        m_life  = lc;
        m_frame = (m_frame + 1) % 64;
    endfunction

    function automatic logic [12:0] model_pixel(input int x, input int y);
        logic        on;
        logic [11:0] rgb;
        bit          lit;
        on  = 1'b0;
        rgb = 12'h000;
        for (int i = 0; i < 5; i++) begin
            int ox;
            ox = 8 + 20 * i;
            if (x >= ox && x < ox + 16 && y >= 8 && y < 24) begin
                if (heart_art[(y - 8) / 2].getc((x - ox) / 2) == "#") begin
                    lit = (m_mode != 2) && (i < m_life);
                    if (m_mode == 1 && i >= m_lo && i < m_hi) lit = ((m_frame / 4) % 2) == 1;
                    on  = 1'b1;
                    rgb = lit ? 12'hF00 : 12'h444;
                end
            end
        end
        if (m_mode == 2 && ((m_frame / 16) % 2) == 0 &&
            x >= 224 && x < 416 && y >= 224 && y < 256) begin
            on  = 1'b1;
            rgb = (x < 226 || x >= 414 || y < 226 || y >= 254) ? 12'hFFF : 12'h800;
        end
        return {on, rgb};
    endfunction

    task automatic do_tick(input int l, input bit g);
        hud_if.life       = 3'(l);
        hud_if.gameover   = g;
        hud_if.frame_tick = 1'b1;
        @(posedge clk);
        model_tick(l, g);
        #1;
        hud_if.frame_tick = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input string tag);
        logic [12:0] exp;
        hud_if.pixel_x = 10'(x);
        hud_if.pixel_y = 10'(y);
        exp = model_pixel(x, y);
        @(posedge clk);
        #1;
        check($sformatf("%s(%0d,%0d).on", tag, x, y), 32'(hud_if.hud_on), 32'(exp[12]));
        check($sformatf("%s(%0d,%0d).rgb", tag, x, y), 32'(hud_if.hud_rgb), 32'(exp[11:0]));
        check($sformatf("%s.flash", tag), 32'(hud_if.flash_active), 32'(m_mode == 1));
    endtask

    task automatic probe_slots(input string tag);
        for (int i = 0; i < 5; i++) probe(8 + 20 * i + 2, 10, tag);
    endtask

    int cur_life;
    bit cur_go;

    initial begin
        model_reset();
        reset_n           = 1'b0;
        hud_if.frame_tick = 1'b0;
        hud_if.pixel_x    = 10'd10;
        hud_if.pixel_y    = 10'd10;
        hud_if.life       = 3'd5;
        hud_if.gameover   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.on", 32'(hud_if.hud_on), 32'd0);
        check("rst.rgb", 32'(hud_if.hud_rgb), 32'd0);
        check("rst.flash", 32'(hud_if.flash_active), 32'd0);
        reset_n = 1'b1;

        // Full hearts, off-HUD pixel, glyph-clear pixel and slot edges.
        do_tick(5, 0);
        probe_slots("full");
        probe(200, 200, "offhud");
        probe(8, 8, "clear");
        probe(23, 10, "edge");
        probe(24, 10, "gap");
        probe(28, 10, "slot1");
        probe(14, 21, "row6");
        probe(10, 23, "row7");
        probe(1023, 10, "xmax");

        // Drop 5->3 and run the blink out.
        do_tick(3, 0);
        probe_slots("drop");
        for (int t = 0; t < 32; t++) begin
            do_tick(3, 0);
            probe(8 + 20 * 3 + 2, 10, "blink3");
            probe(8 + 20 * 4 + 2, 10, "blink4");
            probe(8 + 20 * 2 + 2, 10, "keep2");
        end

        // Second drop during a blink, then a refill.
        do_tick(5, 0);
        do_tick(3, 0);
        do_tick(3, 0);
        do_tick(2, 0);
        for (int t = 0; t < 8; t++) begin
            do_tick(2, 0);
            probe_slots("redrop");
        end
        do_tick(5, 0);
        probe_slots("refill");

        // Drop and gameover together; banner blink and edges.
        do_tick(3, 1);
        probe(320, 240, "banner");
        probe(224, 240, "bleft");
        probe(225, 240, "bleft1");
        probe(226, 240, "binner");
        probe(415, 240, "bright");
        probe(416, 240, "boutside");
        probe(320, 224, "btop");
        probe(320, 255, "bbot");
        probe(320, 256, "bbelow");
        probe_slots("over");
        for (int t = 0; t < 34; t++) begin
            do_tick(3, 1);
            probe(320, 240, "bblink");
        end

        // Leave gameover with an out-of-range life; mid-frame changes are ignored.
        do_tick(7, 0);
        probe_slots("clamp");
        hud_if.life = 3'd1;
        probe_slots("ignored");
        hud_if.gameover = 1'b1;
        probe(320, 240, "ignored_go");
        do_tick(1, 0);
        probe_slots("late");

        // Reset in the middle of a game-over frame.
        do_tick(1, 1);
        while (m_frame % 32 >= 16) do_tick(1, 1);
        hud_if.pixel_x = 10'd320;
        hud_if.pixel_y = 10'd240;
        reset_n        = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.on", 32'(hud_if.hud_on), 32'd0);
        check("midrst.rgb", 32'(hud_if.hud_rgb), 32'd0);
        check("midrst.flash", 32'(hud_if.flash_active), 32'd0);
        model_reset();
        reset_n = 1'b1;
        probe(320, 240, "postrst");
        probe_slots("postrst");
        do_tick(5, 0);
        probe_slots("postrst_tick");

        // Random frames with random life traffic between ticks.
        cur_life = 5;
        cur_go   = 1'b0;
        for (int f = 0; f < 400; f++) begin
            case ($urandom_range(0, 5))
                0:       cur_life = (cur_life > 0) ? cur_life - 1 : 0;
                1:       cur_life = (cur_life > 1) ? cur_life - 2 : 0;
                2:       cur_life = $urandom_range(0, 7);
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) cur_go = ~cur_go;
            do_tick(cur_life, cur_go);
            for (int p = 0; p < 6; p++) begin
                int x, y;
                hud_if.life     = 3'($urandom_range(0, 7));
                hud_if.gameover = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0: begin x = $urandom_range(0, 115); y = $urandom_range(0, 31); end
                    1: begin x = $urandom_range(216, 424); y = $urandom_range(216, 264); end
                    default: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
                endcase
                probe(x, y, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/life_hud_renderer.md
Name: life_hud_renderer

Overview:
- Consumer side of the life/gameover status interface: turns the life counter and gameover flag into HUD pixels on the 640x480 VGA scan.
- Draws a row of heart slots in the top-left corner and blinks lost hearts for a fixed number of frames.
- Draws a blinking GAME OVER banner while gameover is high.
- Its output is muxed over the playfield by the top-level pixel pipeline.

Parameters:
- MAX_LIFE, 5, number of heart slots drawn; life values above this are clamped.
- HUD_X0, 8, left pixel column of slot 0.
- HUD_Y0, 8, top pixel row of the heart row.
- SLOT_PITCH, 20, horizontal pixel distance between slot origins.
- FLASH_FRAMES, 32, frames a lost heart blinks after a life drop.
- BANNER_W, 192, GAME OVER banner width in pixels, centred horizontally.
- BANNER_H, 32, banner height in pixels, centred vertically.

Ports:
- clk  in  1  pixel-pipeline clock.
- reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at the start of vertical blank.
- pixel_x  in  10  current scan column.
- pixel_y  in  10  current scan row.
- life  in  3  live life count from the life controller.
- gameover  in  1  gameover flag from the life controller.
- hud_on  out  1  HUD owns this pixel.
- hud_rgb  out  12  HUD pixel colour, 4:4:4.
- flash_active  out  1  high while a lost-heart blink is running.

Behaviour:
- Reset values: hud_on=0, hud_rgb=0, flash_active=0. State=IDLE, life_q=MAX_LIFE, frame_cnt=0, flash_cnt=0.
- Sampling:
  - life and gameover are sampled only on a frame_tick cycle, so the HUD never tears mid-frame.
  - life_c = min(life, MAX_LIFE).
  - frame_cnt is 6 bits, increments every frame_tick and wraps 63->0.
- State machine, evaluated only on a frame_tick cycle:
  - IDLE:
    - gameover=1 -> GAMEOVER.
    - else life_c<life_q -> FLASH with flash_lo=life_c, flash_hi=life_q, flash_cnt=FLASH_FRAMES-1.
    - life_q<=life_c in all cases.
  - FLASH:
    - gameover=1 -> GAMEOVER, which has priority over a simultaneous drop.
    - else life_c<life_q -> restart the blink with flash_lo=life_c; flash_hi is kept; flash_cnt reloads.
    - else life_c>life_q (refill or reset) -> IDLE immediately.
    - else flash_cnt==0 -> IDLE.
    - else flash_cnt-1.
  - GAMEOVER:
    - gameover=0 -> IDLE with life_q<=life_c, and no flash is started.
- Heart drawing:
  - Slot i (0..MAX_LIFE-1) covers x in [HUD_X0+i*SLOT_PITCH, +16) and y in [HUD_Y0, +16).
  - Each slot is an 8x8 constant heart bitmap scaled x2; index with (x-origin)>>1 and (y-origin)>>1.
  - A bitmap-set pixel is FILLED when i<life_q, otherwise EMPTY.
  - In FLASH, slots in [flash_lo, flash_hi) are FILLED when frame_cnt[2]=1 and EMPTY when it is 0.
  - In GAMEOVER, all slots are EMPTY.
  - Bitmap-clear pixels inside a slot give hud_on=0.
- Banner:
  - Shown in GAMEOVER only, when frame_cnt[4]=0 (16 frames on, 16 off).
  - Covers the rectangle centred at (320,240).
  - The 2-pixel border uses BORDER colour; the interior uses BANNER colour.
  - The banner overlays the hearts, but the two regions never overlap at default parameters.
- Outputs:
  - hud_on and hud_rgb are registered: exactly 1 cycle latency from pixel_x/pixel_y.
  - Off-HUD pixels give hud_on=0 and hud_rgb=0.
  - flash_active is a registered decode of state==FLASH.
- Width rule: slot index computation must not overflow for pixel_x up to 1023. Use an 11-bit compare against origin+16.
- Reset mid-frame: the outputs are 0 on the next cycle. Drawing resumes with full hearts from the following pixel.

Decomposition:
- Shared package holds: HUD colour constants (FILLED=12'hF00, EMPTY=12'h444, BANNER=12'h800, BORDER=12'hFFF), the state enum (IDLE/FLASH/GAMEOVER), and the 8x8 heart bitmap constant.
- One sub-module, hud_slot_decoder: combinational; takes pixel_x, pixel_y and produces in_slot, slot_idx, and bitmap row/col.
- State machine, counters and output register stay in life_hud_renderer.

Test Plan:
- Reset, then life=5 with a frame_tick: pixel (8,8)+bitmap-set offset gives hud_on=1 and rgb=12'hF00 one cycle later in all 5 slots; pixel (200,200) gives hud_on=0.
- life 5->3 at a frame_tick: flash_active=1 and slots 3,4 alternate FILLED/EMPTY every 4 frames. After 32 ticks the FSM is in IDLE, flash_active=0, and slots 3,4 are EMPTY.
- During FLASH, life 3->2: flash_cnt reloads and slots 2..4 blink. Then life jumps to 5 (reset): next tick is IDLE with all slots FILLED.
- life drop and gameover=1 on the same tick: GAMEOVER and flash_active=0. Pixel (320,240) gives rgb=12'h800 for frame_cnt[4]=0 and hud_on=0 for frame_cnt[4]=1. Banner edge pixel gives 12'hFFF.
- life=7 -> clamped to 5 filled slots. life changes between ticks are ignored until the next frame_tick.
- reset_n low mid-scan during GAMEOVER: outputs 0 the next cycle; after release, frame_tick with life=5 gives IDLE and full hearts.
